data_memory_arbiter: RTL

Two-port round-robin arbiter that shares the single-ported data memory between the pipeline memory stage (port 0) and the load/store-multiple sequencer (port 1). It drives the data memory's address, write-data and write-enable lines from the granted requester and registers returned read data per port. An optional lock lets one port hold the memory for a bounded burst of back-to-back transfers, such as an LM/SM sequence of up to 8 registers.

---
 rtl/data_memory_arbiter_if.sv | 47 ++++
 rtl/data_memory_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the data memory.
// master = requesters plus memory read path, slave = arbiter.
interface data_memory_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              Req_0;
   logic              Wr_0;
   logic              Lock_0;
   logic [ADDR_W-1:0] Addr_0;
   logic [DATA_W-1:0] Wdata_0;
   logic              Gnt_0;
   logic [DATA_W-1:0] Rdata_0;
   logic              Rvalid_0;

   logic              Req_1;
   logic              Wr_1;
   logic              Lock_1;
   logic [ADDR_W-1:0] Addr_1;
   logic [DATA_W-1:0] Wdata_1;
   logic              Gnt_1;
   logic [DATA_W-1:0] Rdata_1;
   logic              Rvalid_1;

   logic [ADDR_W-1:0] Mem_Address;
   logic [DATA_W-1:0] Mem_Write_Data;
   logic              Mem_Write_Read;
   logic [DATA_W-1:0] Mem_Read_Data;

   modport master (
      output Req_0, Wr_0, Lock_0, Addr_0, Wdata_0,
      output Req_1, Wr_1, Lock_1, Addr_1, Wdata_1,
      input  Gnt_0, Rdata_0, Rvalid_0,
      input  Gnt_1, Rdata_1, Rvalid_1,
      input  Mem_Address, Mem_Write_Data, Mem_Write_Read,
      output Mem_Read_Data
   );

   modport slave (
      input  Req_0, Wr_0, Lock_0, Addr_0, Wdata_0,
      input  Req_1, Wr_1, Lock_1, Addr_1, Wdata_1,
      output Gnt_0, Rdata_0, Rvalid_0,
      output Gnt_1, Rdata_1, Rvalid_1,
      output Mem_Address, Mem_Write_Data, Mem_Write_Read,
      input  Mem_Read_Data
   );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter for the single-ported data memory (port 0 = MEM stage, port 1 = LM/SM).
// Define DMEM_ARB_LOCK_EN to enable bounded locked bursts; otherwise pure round-robin.
module data_memory_arbiter #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   data_memory_arbiter_if.slave bus
);

   logic              gnt0, gnt1;
   logic              xfer0, xfer1;
   logic              hold0, hold1;
   logic              prio_q, prio_d;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;
   logic              wr_mux;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;
   logic              rvalid0_q, rvalid1_q;

`ifdef DMEM_ARB_LOCK_EN
   typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_e;
   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             cnt_last;
   logic             free;

   assign cnt_inc  = cnt_q + CNT_W'(1);
   assign cnt_last = (cnt_inc == CNT_W'(MAX_LOCK));
   assign hold0    = (state_q == LOCKED0) && bus.Req_0;
   assign hold1    = (state_q == LOCKED1) && bus.Req_1;
`else
   logic unused_lock;
   assign unused_lock = bus.Lock_0 ^ bus.Lock_1;
   assign hold0       = 1'b0;
   assign hold1       = 1'b0;
`endif

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst_i) begin
         if (hold0) begin
            gnt0 = 1'b1;
         end else if (hold1) begin
            gnt1 = 1'b1;
         end else if (bus.Req_0 && bus.Req_1) begin
            gnt0 = !prio_q;
            gnt1 = prio_q;
         end else begin
            gnt0 = bus.Req_0;
            gnt1 = bus.Req_1;
         end
      end
   end

   assign xfer0 = bus.Req_0 && gnt0;
   assign xfer1 = bus.Req_1 && gnt1;

   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      wr_mux    = 1'b0;
      if (gnt0) begin
         addr_mux  = bus.Addr_0;
         wdata_mux = bus.Wdata_0;
         wr_mux    = bus.Wr_0;
      end else if (gnt1) begin
         addr_mux  = bus.Addr_1;
         wdata_mux = bus.Wdata_1;
         wr_mux    = bus.Wr_1;
      end
   end

`ifdef DMEM_ARB_LOCK_EN
   // A lapsed lock (owner dropped Req) falls through to the unlocked path so the
   // other port's same-cycle transfer updates prio and may start its own lock.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prio_d  = prio_q;
      free    = 1'b1;
      unique case (state_q)
         LOCKED0: begin
            if (bus.Req_0) begin
               free = 1'b0;
               if (bus.Lock_0 && !cnt_last) begin
                  cnt_d = cnt_inc;
               end else begin
                  state_d = UNLOCKED;
                  cnt_d   = '0;
                  prio_d  = 1'b1;
               end
            end else begin
               state_d = UNLOCKED;
               cnt_d   = '0;
               prio_d  = 1'b1;
            end
         end
         LOCKED1: begin
            if (bus.Req_1) begin
               free = 1'b0;
               if (bus.Lock_1 && !cnt_last) begin
                  cnt_d = cnt_inc;
               end else begin
                  state_d = UNLOCKED;
                  cnt_d   = '0;
                  prio_d  = 1'b0;
               end
            end else begin
               state_d = UNLOCKED;
               cnt_d   = '0;
               prio_d  = 1'b0;
            end
         end
         default: ;
      endcase
      if (free && (xfer0 || xfer1)) begin
         prio_d = xfer0;
         if (xfer0 && bus.Lock_0) begin
            state_d = LOCKED0;
            cnt_d   = CNT_W'(1);
         end else if (xfer1 && bus.Lock_1) begin
            state_d = LOCKED1;
            cnt_d   = CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= UNLOCKED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   always_comb begin
      prio_d = prio_q;
      if (xfer0) begin
         prio_d = 1'b1;
      end else if (xfer1) begin
         prio_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q    <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         prio_q    <= prio_d;
         rvalid0_q <= xfer0 && !bus.Wr_0;
         rvalid1_q <= xfer1 && !bus.Wr_1;
         if (xfer0 && !bus.Wr_0) rdata0_q <= bus.Mem_Read_Data;
         if (xfer1 && !bus.Wr_1) rdata1_q <= bus.Mem_Read_Data;
      end
   end

   assign bus.Gnt_0          = gnt0;
   assign bus.Gnt_1          = gnt1;
   assign bus.Rdata_0        = rdata0_q;
   assign bus.Rdata_1        = rdata1_q;
   assign bus.Rvalid_0       = rvalid0_q;
   assign bus.Rvalid_1       = rvalid1_q;
   assign bus.Mem_Address    = addr_mux;
   assign bus.Mem_Write_Data = wdata_mux;
   assign bus.Mem_Write_Read = wr_mux;

endmodule
